// File: rtl/idp_enc_37_seq_if.sv
// Handshake bus between a word source, the FNS encoder and the downstream decoder stage.
`ifndef IBLEN37
`define IBLEN37 27
`endif

interface idp_enc_37_seq_if;
  logic [`IBLEN37-1:0] datain;
  logic                din_valid;
  logic                din_ready;
  logic [36:0]         codeout;
  logic                cout_valid;
  logic                cout_ready;
  logic                busy;
  logic                err;

  modport master (
    output datain, din_valid, cout_ready,
    input  din_ready, codeout, cout_valid, busy, err
  );

  modport slave (
    input  datain, din_valid, cout_ready,
    output din_ready, codeout, cout_valid, busy, err
  );
endinterface

// File: rtl/idp_enc_37_seq.sv
// Sequential greedy binary-to-FNS encoder, one codeword bit per cycle, 37-bit codeword.
// Optional range check enabled by defining IDP_ENC_RANGE_CHK_EN (err = leftover remainder).
`ifndef IBLEN37
`define IBLEN37 27
`endif
`ifndef FNS1
`define FNS1  1
`define FNS2  2
`define FNS3  3
`define FNS4  5
`define FNS5  8
`define FNS6  13
`define FNS7  21
`define FNS8  34
`define FNS9  55
`define FNS10 89
`define FNS11 144
`define FNS12 233
`define FNS13 377
`define FNS14 610
`define FNS15 987
`define FNS16 1597
`define FNS17 2584
`define FNS18 4181
`define FNS19 6765
`define FNS20 10946
`define FNS21 17711
`define FNS22 28657
`define FNS23 46368
`define FNS24 75025
`define FNS25 121393
`define FNS26 196418
`define FNS27 317811
`define FNS28 514229
`define FNS29 832040
`define FNS30 1346269
`define FNS31 2178309
`define FNS32 3524578
`define FNS33 5702887
`define FNS34 9227465
`define FNS35 14930352
`define FNS36 24157817
`define FNS37 39088169
`endif

module idp_enc_37_seq (
  input  logic             clk,
  input  logic             rst,
  idp_enc_37_seq_if.slave  bus
);

  localparam int unsigned IW    = `IBLEN37;
  localparam int unsigned CW    = 37;
  localparam int unsigned CNTW  = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // Bits 34 and 35 share the top weight; bit 36 carries the next one down.
  localparam logic [IW-1:0] WT [CW] = '{
    IW'(`FNS1),  IW'(`FNS2),  IW'(`FNS3),  IW'(`FNS4),  IW'(`FNS5),
    IW'(`FNS6),  IW'(`FNS7),  IW'(`FNS8),  IW'(`FNS9),  IW'(`FNS10),
    IW'(`FNS11), IW'(`FNS12), IW'(`FNS13), IW'(`FNS14), IW'(`FNS15),
    IW'(`FNS16), IW'(`FNS17), IW'(`FNS18), IW'(`FNS19), IW'(`FNS20),
    IW'(`FNS21), IW'(`FNS22), IW'(`FNS23), IW'(`FNS24), IW'(`FNS25),
    IW'(`FNS26), IW'(`FNS27), IW'(`FNS28), IW'(`FNS29), IW'(`FNS30),
    IW'(`FNS31), IW'(`FNS32), IW'(`FNS33), IW'(`FNS34),
    IW'(`FNS37), IW'(`FNS37), IW'(`FNS36)
  };

  logic [1:0]      state, state_nx;
  logic [IW-1:0]   rem, rem_nx;
  logic [CW-1:0]   code, code_nx;
  logic [CNTW-1:0] cnt;
  logic [5:0]      bit_idx;
  logic [IW-1:0]   cur_w;
  logic            take;
  logic            accept;
  logic            last_step;
  logic            din_ready_q;
  logic            cout_valid_q;
  logic            busy_q;

  // Step-to-bit mapping keeps weights non-increasing: 35, 34, 36, then 33..0.
  always_comb begin
    bit_idx = 6'd36 - cnt;
    if (cnt == 6'd0)      bit_idx = 6'd35;
    else if (cnt == 6'd1) bit_idx = 6'd34;
    else if (cnt == 6'd2) bit_idx = 6'd36;
  end

  always_comb begin
    cur_w     = WT[bit_idx];
    take      = (rem >= cur_w);
    rem_nx    = take ? (rem - cur_w) : rem;
    code_nx   = code | (CW'(take) << bit_idx);
    accept    = (state == S_IDLE) && bus.din_valid && din_ready_q;
    last_step = (cnt == CNTW'(CW - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ENC;
      S_ENC:   if (last_step) state_nx = S_OUT;
      S_OUT:   if (bus.cout_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rem          <= '0;
      code         <= '0;
      cnt          <= '0;
      din_ready_q  <= 1'b0;
      cout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      din_ready_q  <= (state_nx == S_IDLE);
      cout_valid_q <= (state_nx == S_OUT);
      busy_q       <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            rem  <= bus.datain;
            code <= '0;
            cnt  <= '0;
          end
        end
        S_ENC: begin
          rem  <= rem_nx;
          code <= code_nx;
          if (!last_step) cnt <= cnt + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IDP_ENC_RANGE_CHK_EN
  logic err_q;

  // A leftover remainder after the last step means the word was out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == S_ENC) && last_step) begin
      err_q <= (rem_nx != '0);
    end else if ((state == S_OUT) && bus.cout_ready) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.din_ready  = din_ready_q;
  assign bus.cout_valid = cout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.codeout    = code;

endmodule
